// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter: funct3 codes, FSM states,
// the latched request descriptor and the access legality check.
package dmem_pkg;

    localparam int unsigned F3_BITS   = 3;
    localparam int unsigned NUM_PORTS = 2;

    localparam logic [F3_BITS-1:0] F3_B  = 3'b000;
    localparam logic [F3_BITS-1:0] F3_H  = 3'b001;
    localparam logic [F3_BITS-1:0] F3_W  = 3'b010;
    localparam logic [F3_BITS-1:0] F3_BU = 3'b100;
    localparam logic [F3_BITS-1:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Control part of a granted request; address and data are kept separately
    // because their widths are parameters of the top.
    typedef struct packed {
        logic               we;
        logic [F3_BITS-1:0] funct3;
        logic               port;
        logic               legal;
    } req_ctl_t;

    // Unsigned widths exist only for loads; stores use B/H/W.
    function automatic logic is_legal(input logic               we,
                                      input logic [F3_BITS-1:0] f3,
                                      input logic [1:0]         addr_lo);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_BU:   ok = ~we;
            F3_H:    ok = ~addr_lo[0];
            F3_HU:   ok = ~we & ~addr_lo[0];
            F3_W:    ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: request handshake plus the
// one-cycle response pulse. The requester uses master, the arbiter uses slave.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();

    logic              valid;
    logic              ready;
    logic              we;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output valid, we, funct3, addr, wdata,
        input  ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  valid, we, funct3, addr, wdata,
        output ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_rr_arb.sv
// Two-way request picker. Produces a one-hot grant when enabled; on a tie it
// alternates away from the last winner, or always favours port 0 in fixed mode.
module dmem_rr_arb (
    input  logic [1:0] i_valid,
    input  logic       i_last_grant,
    input  logic       i_en,
    input  logic       i_prio_fix,
    output logic [1:0] o_gnt_c
);

    always_comb begin
        o_gnt_c = 2'b00;
        if (i_en) begin
            if (i_valid == 2'b11) begin
                o_gnt_c = (i_prio_fix || i_last_grant) ? 2'b01 : 2'b10;
            end else begin
                o_gnt_c = i_valid;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of data_memory: one access in flight,
// alignment check at grant, single-cycle strobe, one-cycle response to the owner.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter bit          PRIO_FIX = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    dmem_arbiter_if.slave     p0,
    dmem_arbiter_if.slave     p1,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [2:0]        funct3,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] WriteData,
    input  logic [DATA_W-1:0] ReadData,
    input  logic              misaligned
);

    state_t            r_state;
    state_t            w_next_state;
    logic              r_last_grant;

    logic [1:0]        w_valid;
    logic [1:0]        w_gnt;
    logic              w_grant_en;
    logic              w_granted;
    logic              w_sel;

    logic              w_we;
    logic [2:0]        w_f3;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_legal;

    req_ctl_t          r_ctl;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_mem_read;
    logic              r_mem_write;

    logic [1:0]        w_own;
    logic              w_rsp_err;
    logic [DATA_W-1:0] w_rsp_rdata;
    logic [1:0]        r_rsp_valid;
    logic [1:0]        r_rsp_err;
    logic [DATA_W-1:0] r_rsp_rdata0;
    logic [DATA_W-1:0] r_rsp_rdata1;

    // Arbitration: a new grant may only be issued while no access occupies memory.
    assign w_valid    = {p1.valid, p0.valid};
    assign w_grant_en = (r_state == ST_IDLE) || (r_state == ST_RESP);

    dmem_rr_arb u_arb (
        .i_valid      (w_valid),
        .i_last_grant (r_last_grant),
        .i_en         (w_grant_en),
        .i_prio_fix   (PRIO_FIX),
        .o_gnt_c      (w_gnt)
    );

    assign w_granted = |w_gnt;
    assign w_sel     = w_gnt[1];
    assign p0.ready  = w_gnt[0];
    assign p1.ready  = w_gnt[1];

    assign w_we    = w_sel ? p1.we     : p0.we;
    assign w_f3    = w_sel ? p1.funct3 : p0.funct3;
    assign w_addr  = w_sel ? p1.addr   : p0.addr;
    assign w_wdata = w_sel ? p1.wdata  : p0.wdata;
    assign w_legal = is_legal(w_we, w_f3, w_addr[1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_granted) w_next_state = ST_MEM;
            ST_MEM:  w_next_state = ST_RESP;
            ST_RESP: w_next_state = w_granted ? ST_MEM : ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Request registers and the memory strobes for the following MEM cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_ctl        <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
        end else begin
            r_mem_read  <= w_granted & ~w_we & w_legal;
            r_mem_write <= w_granted &  w_we & w_legal;
            if (w_granted) begin
                r_last_grant <= w_sel;
                r_ctl        <= '{we: w_we, funct3: w_f3, port: w_sel, legal: w_legal};
                r_addr       <= w_addr;
                r_wdata      <= w_wdata;
            end
        end
    end

    assign MemRead   = r_mem_read;
    assign MemWrite  = r_mem_write;
    assign funct3    = r_ctl.funct3;
    assign address   = r_addr;
    assign WriteData = r_wdata;

    // Response is formed at the end of MEM and presented during RESP to the owner only.
    assign w_own       = (r_state == ST_MEM) ? {r_ctl.port, ~r_ctl.port} : 2'b00;
    assign w_rsp_err   = ~r_ctl.legal | misaligned;
    assign w_rsp_rdata = (~r_ctl.we && ~w_rsp_err) ? ReadData : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid  <= 2'b00;
            r_rsp_err    <= 2'b00;
            r_rsp_rdata0 <= '0;
            r_rsp_rdata1 <= '0;
        end else begin
            r_rsp_valid  <= w_own;
            r_rsp_err    <= w_own & {2{w_rsp_err}};
            r_rsp_rdata0 <= w_own[0] ? w_rsp_rdata : '0;
            r_rsp_rdata1 <= w_own[1] ? w_rsp_rdata : '0;
        end
    end

    assign p0.rsp_valid = r_rsp_valid[0];
    assign p0.rsp_err   = r_rsp_err[0];
    assign p0.rsp_rdata = r_rsp_rdata0;
    assign p1.rsp_valid = r_rsp_valid[1];
    assign p1.rsp_err   = r_rsp_err[1];
    assign p1.rsp_rdata = r_rsp_rdata1;

endmodule
